uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Synthesizable 8N1 UART receiver for the user project, paired with the transmitter that drives mprj_io[5].
- Recovers bytes from the serial line by mid-bit sampling.
- Queues received bytes in a small first-word-fall-through (FWFT) FIFO and exposes them to the Wishbone/ISR side through a valid/ready handshake.
- Reports framing and overrun errors through sticky flags and a level interrupt.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per bit (40 MHz / 115200); minimum 8.
- FIFO_DEPTH, 4, byte entries; power of 2, at least 2.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous, active-high reset
- rx_i  in  1  asynchronous serial input; idles high
- rx_data_o  out  8  byte at the FIFO head
- rx_valid_o  out  1  FIFO not empty
- rx_ready_i  in  1  consumer pops the head when rx_valid_o && rx_ready_i
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err_o  out  1  sticky: stop bit sampled as 0
- overrun_o  out  1  sticky: byte dropped because the FIFO was full
- clear_i  in  1  one-cycle pulse that clears frame_err_o and overrun_o
- irq_o  out  1  rx_valid_o | frame_err_o | overrun_o

Behaviour:
- Reset values:
  - rx_data_o=0x00, rx_valid_o=0, fifo_count_o=0, frame_err_o=0, overrun_o=0, irq_o=0.
  - FSM=IDLE; both synchronizer flops=1.
- Reset applied mid-frame aborts the frame; the partial byte is discarded.
- Input path: two-flop synchronizer produces rx_s. All decisions use rx_s, so line-to-decision latency is 2 cycles.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0.
- FSM:
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at counter==CLKS_PER_BIT/2-1, sample rx_s.
    - 1 -> false start (glitch), return to IDLE.
    - 0 -> DATA, counter=0, bit index=0.
  - DATA: at counter==CLKS_PER_BIT-1, shift rx_s into the byte, LSB first. After bit index 7 -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> push the byte, go to IDLE.
    - 0 -> set frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line yields exactly one frame error, not repeated frames.
- Push rules:
  - Pushed byte appears on rx_data_o, with rx_valid_o=1, on the cycle after the stop-bit sample when the FIFO was empty.
  - FIFO full at push -> byte dropped, overrun_o set, FIFO contents unchanged.
  - Full and a pop in the same cycle -> pop first; the push is accepted; no overrun.
- FIFO:
  - FWFT: rx_data_o always shows the head.
  - Pop on rx_valid_o && rx_ready_i.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when non-empty leaves fifo_count_o unchanged.
  - rx_ready_i while empty is ignored.
- Flags:
  - frame_err_o and overrun_o hold until clear_i or reset.
  - An error event coinciding with clear_i wins: the flag stays set.
- irq_o is combinational from registered signals; no extra latency.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1 with a PARITY state between DATA and STOP.
  - Parity sampled at counter==CLKS_PER_BIT-1; a mismatch with even parity of the data sets sticky parity_err_o.
  - parity_err_o is a 1-bit output, reset 0, cleared by clear_i, and ORed into irq_o.
  - A byte with a parity error is still pushed.
- Undefined: no PARITY state; the parity_err_o port is absent; 8N1 only.

Test Plan:
1. Single byte:
   - Stimulus: after reset, send 0x0F at CLKS_PER_BIT=347 (8675 ns/bit, 25 ns clock).
   - Required: rx_valid_o=1, rx_data_o=0x0F, fifo_count_o=1 within 3 cycles after the stop-bit centre; no flags set.
2. Back-to-back FIFO:
   - Stimulus: rx_ready_i=0; send 0x0F, 0x3D, 0x0F, 0x3D.
   - Required: fifo_count_o=4.
   - Then rx_ready_i=1: pops 0x0F, 0x3D, 0x0F, 0x3D in order, one per cycle; rx_valid_o=0 after the fourth pop.
3. Overrun:
   - Stimulus: FIFO full (4 entries), send 0xA5.
   - Required: overrun_o=1, irq_o=1, contents unchanged; clear_i pulse -> overrun_o=0.
   - Repeat with rx_ready_i=1 exactly on the push cycle -> no overrun, fifo_count_o stays 4, tail=0xA5.
4. Framing/break:
   - Stimulus: send 0x3D with stop bit 0, then hold the line low for 20 bit times.
   - Required: single frame_err_o=1, no byte pushed; the next valid 0x0F is received correctly after the line returns high.
5. Glitch and reset:
   - Stimulus: a 100-cycle low pulse on an idle line.
   - Required: FSM returns to IDLE, nothing pushed.
   - Stimulus: assert wb_rst_i during DATA bit 4.
   - Required: all outputs at reset values the next cycle; the following 0x3D is received intact.
6. Parity (UART_RX_PARITY_EN defined):
   - Stimulus: send 0x0F with parity bit 1.
   - Required: parity_err_o=1, byte 0x0F still queued.
   - Stimulus: send 0x0F with parity bit 0.
   - Required: no error.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Consumer-side bundle of the UART receiver. It carries the FIFO
//               head byte, the valid/ready pop handshake, the occupancy, the
//               sticky error flags with their clear strobe, and the interrupt.
//               The slave modport is the receiver. The master modport is the
//               Wishbone/ISR consumer.
//               Optional macro UART_RX_PARITY_EN adds parity_err_o.
// Signals     : rx_data_o    8   byte at the FIFO head (FWFT)
//               rx_valid_o   1   FIFO not empty
//               rx_ready_i   1   pop request
//               fifo_count_o W   occupancy, W = $clog2(FIFO_DEPTH)+1
//               frame_err_o  1   sticky framing error
//               overrun_o    1   sticky overrun
//               parity_err_o 1   sticky parity error (UART_RX_PARITY_EN only)
//               clear_i      1   one-cycle flag clear
//               irq_o        1   level interrupt
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int C_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         rx_data_o;
    logic               rx_valid_o;
    logic               rx_ready_i;
    logic [C_CNT_W-1:0] fifo_count_o;
    logic               frame_err_o;
    logic               overrun_o;
`ifdef UART_RX_PARITY_EN
    logic               parity_err_o;
`endif
    logic               clear_i;
    logic               irq_o;

`ifdef UART_RX_PARITY_EN
    modport slave (
        output rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o,
               parity_err_o, irq_o,
        input  rx_ready_i, clear_i
    );
    modport master (
        input  rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o,
               parity_err_o, irq_o,
        output rx_ready_i, clear_i
    );
`else
    modport slave (
        output rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o,
               irq_o,
        input  rx_ready_i, clear_i
    );
    modport master (
        input  rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o,
               irq_o,
        output rx_ready_i, clear_i
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver using mid-bit sampling. Received bytes go into
//               a first-word-fall-through FIFO, which is drained through a
//               valid/ready handshake. Framing and overrun errors are kept as
//               sticky flags and drive a level interrupt.
//               Optional macro UART_RX_PARITY_EN selects 8E1 framing and adds a
//               sticky parity error flag.
// Ports       : wb_clk_i  in   system clock
//               wb_rst_i  in   synchronous active-high reset
//               rx_i      in   asynchronous serial line, idles high
//               bus       slave modport of uart_rx_fifo_if (FIFO and flags)
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic       wb_clk_i,
    input  wire logic       wb_rst_i,
    input  wire logic       rx_i,
    uart_rx_fifo_if.slave   bus
);
    localparam int C_TIM_W = $clog2(CLKS_PER_BIT);
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_TIM_W-1:0] C_LAST = C_TIM_W'(CLKS_PER_BIT - 1);
    localparam logic [C_TIM_W-1:0] C_HALF = C_TIM_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 rx_s_q;
    logic [C_TIM_W-1:0]   tim_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [C_PTR_W-1:0]   wr_ptr_q;
    logic [C_PTR_W-1:0]   rd_ptr_q;
    logic [C_CNT_W-1:0]   count_q;
    logic [C_CNT_W-1:0]   count_d;

    // The stop-bit sample pushes on the same edge. The byte is therefore
    // visible on the head one cycle after the sample.
    logic w_stop_tick;
    logic w_push;
    logic w_frame;
    logic w_pop;
    logic w_push_ok;

    assign w_stop_tick = (state_q == S_STOP) && (tim_q == C_LAST);
    assign w_push      = w_stop_tick && rx_s_q;
    assign w_frame     = w_stop_tick && !rx_s_q;
    assign w_pop       = (count_q != '0) && bus.rx_ready_i;
    // A pop in the same cycle makes room, so a full FIFO still accepts the push.
    assign w_push_ok   = w_push && ((count_q != C_FULL) || w_pop);

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    logic w_par_err;
    assign w_par_err = (state_q == S_PARITY) && (tim_q == C_LAST)
                       && (rx_s_q != (^shift_q));
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            tim_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            case (state_q)
                S_IDLE: begin
                    tim_q <= '0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (tim_q == C_HALF) begin
                        tim_q     <= '0;
                        bit_idx_q <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tim_q <= tim_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tim_q == C_LAST) begin
                        tim_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        tim_q <= tim_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tim_q == C_LAST) begin
                        tim_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        tim_q <= tim_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tim_q == C_LAST) begin
                        tim_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        tim_q <= tim_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high, so a held-low line
                    // produces only one frame error.
                    tim_q <= '0;
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (w_push_ok && !w_pop)      count_d = count_q + C_CNT_W'(1);
        else if (!w_push_ok && w_pop) count_d = count_q - C_CNT_W'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // An error that coincides with clear_i takes priority, so the flag stays set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (w_frame)           frame_err_q <= 1'b1;
            else if (bus.clear_i)  frame_err_q <= 1'b0;
            if (w_push && !w_push_ok) overrun_q <= 1'b1;
            else if (bus.clear_i)     overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)          parity_err_q <= 1'b0;
        else if (w_par_err)    parity_err_q <= 1'b1;
        else if (bus.clear_i)  parity_err_q <= 1'b0;
    end
    assign bus.parity_err_o = parity_err_q;
    assign bus.irq_o = (count_q != '0) | frame_err_q | overrun_q | parity_err_q;
`else
    assign bus.irq_o = (count_q != '0) | frame_err_q | overrun_q;
`endif

    assign bus.rx_data_o    = mem_q[rd_ptr_q];
    assign bus.rx_valid_o   = (count_q != '0);
    assign bus.fifo_count_o = count_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed bench for uart_rx_fifo. A queue-based model tracks the
//               expected FIFO contents and flags. It is compared against the
//               DUT every cycle, outside the short windows around bit samples.
//               Literal checks pin the model at key points.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int CPB   = 347;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #12.5 clk = ~clk;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_i     (rx),
        .bus      (bus)
    );

    // Expected state
    logic [7:0] mq[$];
    bit m_fe, m_ov, m_pe;
    bit settle = 1'b0;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_fe = 0; m_ov = 0; m_pe = 0;
    endtask

    task automatic m_pop();
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic m_push(input logic [7:0] b);
        if (mq.size() == DEPTH) m_ov = 1;
        else mq.push_back(b);
    endtask

    // Per-cycle comparison against the model, sampled 1 ns after the active edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!settle) begin
                chk("cmp_valid", bus.rx_valid_o, int'(mq.size() != 0));
                chk("cmp_count", bus.fifo_count_o, mq.size());
                chk("cmp_frame", bus.frame_err_o, m_fe);
                chk("cmp_ovr",   bus.overrun_o, m_ov);
`ifdef UART_RX_PARITY_EN
                chk("cmp_par",   bus.parity_err_o, m_pe);
                chk("cmp_irq",   bus.irq_o, int'((mq.size() != 0) | m_fe | m_ov | m_pe));
`else
                chk("cmp_irq",   bus.irq_o, int'((mq.size() != 0) | m_fe | m_ov));
`endif
                if (mq.size() != 0) chk("cmp_data", bus.rx_data_o, mq[0]);
            end
        end
    end

    // Sends one frame starting at a negedge. The stop-bit centre falls 3296.5
    // cycles after the start edge. The model is updated 2.5 cycles after it.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input bit pop_on_push, input logic par_v);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_v;
        repeat (CPB / 2) @(negedge clk);
        settle = 1'b1;
        repeat (3) @(negedge clk);
        if (par_v != (^b)) m_pe = 1;
        settle = 1'b0;
        repeat (CPB - CPB / 2 - 3) @(negedge clk);
`else
        if (par_v === 1'bx) $display("unused parity argument");
`endif
        rx = stop_v;
        repeat (CPB / 2) @(negedge clk);
        settle = 1'b1;
        repeat (2) @(negedge clk);
        if (pop_on_push) begin
            bus.rx_ready_i = 1'b1;
            m_pop();
        end
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
        if (stop_v) m_push(b);
        else        m_fe = 1;
        settle = 1'b0;
        repeat (CPB - CPB / 2 - 3) @(negedge clk);
    endtask

    task automatic pop_one();
        bus.rx_ready_i = 1'b1;
        m_pop();
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
    endtask

    task automatic clear_flags();
        bus.clear_i = 1'b1;
        m_fe = 0; m_ov = 0; m_pe = 0;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  bus.rx_data_o, 0);
        chk({tag, "_valid"}, bus.rx_valid_o, 0);
        chk({tag, "_count"}, bus.fifo_count_o, 0);
        chk({tag, "_frame"}, bus.frame_err_o, 0);
        chk({tag, "_ovr"},   bus.overrun_o, 0);
        chk({tag, "_irq"},   bus.irq_o, 0);
    endtask

    initial begin
        #(25.0 * 200000);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain [4];
        logic [7:0] pb;
        drain = '{8'h3D, 8'h0F, 8'h3D, 8'hA5};
        bus.rx_ready_i = 1'b0;
        bus.clear_i    = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        chk("t1_valid", bus.rx_valid_o, 1);
        chk("t1_data",  bus.rx_data_o, 8'h0F);
        chk("t1_count", bus.fifo_count_o, 1);
        chk("t1_flags", {bus.frame_err_o, bus.overrun_o}, 0);
        pop_one();
        chk("t1_empty", bus.rx_valid_o, 0);

        // Back-to-back fill
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        send_frame(8'h3D, 1'b1, 0, 1'b1);
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        send_frame(8'h3D, 1'b1, 0, 1'b1);
        chk("t2_count", bus.fifo_count_o, 4);
        chk("t2_head",  bus.rx_data_o, 8'h0F);

        // Overrun, then push with a simultaneous pop
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("t3_ovr",   bus.overrun_o, 1);
        chk("t3_irq",   bus.irq_o, 1);
        chk("t3_count", bus.fifo_count_o, 4);
        chk("t3_head",  bus.rx_data_o, 8'h0F);
        clear_flags();
        chk("t3_clr",   bus.overrun_o, 0);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        chk("t3b_ovr",   bus.overrun_o, 0);
        chk("t3b_count", bus.fifo_count_o, 4);
        bus.rx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", bus.rx_data_o, drain[i]);
            m_pop();
            @(negedge clk);
        end
        bus.rx_ready_i = 1'b0;
        chk("t3_drained", bus.rx_valid_o, 0);
        // Popping an empty FIFO is ignored
        pop_one();
        chk("t3_empty_pop", bus.fifo_count_o, 0);

        // Framing error followed by a long break
        send_frame(8'h3D, 1'b0, 0, 1'b1);
        chk("t4_frame", bus.frame_err_o, 1);
        chk("t4_count", bus.fifo_count_o, 0);
        chk("t4_irq",   bus.irq_o, 1);
        clear_flags();
        repeat (20 * CPB) @(negedge clk);
        chk("t4_single_err", bus.frame_err_o, 0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        chk("t4_after", bus.rx_data_o, 8'h0F);
        chk("t4_after_count", bus.fifo_count_o, 1);

        // Glitch on an idle line
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t5_glitch_count", bus.fifo_count_o, 1);

        // Reset during data bit 4
        pb = 8'hA5;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            repeat (CPB) @(negedge clk);
        end
        rx = pb[4];
        repeat (100) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        m_reset();
        @(negedge clk);
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("t5_no_partial", bus.fifo_count_o, 0);
        send_frame(8'h3D, 1'b1, 0, 1'b1);
        chk("t5_data",  bus.rx_data_o, 8'h3D);
        chk("t5_count", bus.fifo_count_o, 1);

`ifdef UART_RX_PARITY_EN
        pop_one();
        send_frame(8'h0F, 1'b1, 0, 1'b1);
        chk("t6_perr",  bus.parity_err_o, 1);
        chk("t6_data",  bus.rx_data_o, 8'h0F);
        chk("t6_count", bus.fifo_count_o, 1);
        clear_flags();
        pop_one();
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        chk("t6_ok",       bus.parity_err_o, 0);
        chk("t6_ok_count", bus.fifo_count_o, 1);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
